// File: rtl/uart_rx_1200_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_1200_if
// Brief    : Byte delivery and status bundle of the 1200-baud 8N1 receiver.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_1200_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    output frame_err,
    output overrun,
    output busy
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    input  frame_err,
    input  overrun,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_1200.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_1200
// Brief    : 8N1 serial receiver timed off the system clock, mid-bit sampling,
//            valid/ready holding register with framing and overrun flags.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_1200 #(
  parameter int CLKS_PER_BIT = 10000,
  parameter int CNT_W        = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rxd,
  uart_rx_1200_if.master   bus
);

  localparam logic [CNT_W-1:0] c_half = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] c_full = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_start = 3'd1;
  localparam logic [2:0] c_data  = 3'd2;
  localparam logic [2:0] c_stop  = 3'd3;
  localparam logic [2:0] c_break = 3'd4;

  logic [1:0]       r_sync;
  logic             r_rxs_d;
  logic [1:0]       r_live;
  logic             r_armed;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_timer;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_ferr;
  logic             r_ovr;

  logic             w_rxs;
  logic             w_edge;
  logic             w_half;
  logic             w_full;
  logic             w_commit;
  logic             w_stop_bad;

  assign w_rxs      = r_sync[1];
  // r_armed blocks a frame start until the line has been seen high after reset
  assign w_edge     = r_armed & r_rxs_d & ~w_rxs;
  assign w_half     = (r_timer == c_half);
  assign w_full     = (r_timer == c_full);
  assign w_commit   = (r_state == c_stop) & w_full & w_rxs;
  assign w_stop_bad = (r_state == c_stop) & w_full & ~w_rxs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b11;
      r_rxs_d <= 1'b1;
      r_live  <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], rxd};
      r_rxs_d <= w_rxs;
      r_live  <= {r_live[0], 1'b1};
      r_armed <= r_armed | (r_live[1] & w_rxs);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
      r_timer <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
    end else begin
      case (r_state)
        c_idle: begin
          r_timer <= '0;
          if (w_edge) begin
            r_state <= c_start;
          end
        end
        c_start: begin
          if (w_half) begin
            r_timer <= '0;
            r_idx   <= 3'd0;
            r_state <= w_rxs ? c_idle : c_data;
          end else begin
            r_timer <= r_timer + CNT_W'(1);
          end
        end
        c_data: begin
          if (w_full) begin
            r_shift[r_idx] <= w_rxs;
            r_timer        <= '0;
            r_idx          <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
              r_state <= c_stop;
            end
          end else begin
            r_timer <= r_timer + CNT_W'(1);
          end
        end
        c_stop: begin
          if (w_full) begin
            r_timer <= '0;
            r_state <= w_rxs ? c_idle : c_break;
          end else begin
            r_timer <= r_timer + CNT_W'(1);
          end
        end
        c_break: begin
          r_timer <= '0;
          if (w_rxs) begin
            r_state <= c_idle;
          end
        end
        default: begin
          r_timer <= '0;
          r_state <= c_idle;
        end
      endcase
    end
  end

  // A commit coinciding with an accept keeps the register full without overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_stop_bad;
      r_ovr  <= w_commit & r_valid & ~bus.rx_ready;
      if (w_commit) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid & bus.rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.rx_data   = r_data;
  assign bus.rx_valid  = r_valid;
  assign bus.frame_err = r_ferr;
  assign bus.overrun   = r_ovr;
  assign bus.busy      = (r_state != c_idle);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_1200.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_1200
// Brief    : Self-checking bench for uart_rx_1200 with a frame-level reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_1200;

  localparam int CPB = 16;
  localparam int T   = 10;
  localparam int BIT = CPB * T;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rxd   = 1'b1;

  uart_rx_1200_if bus ();

  uart_rx_1200 #(
    .CLKS_PER_BIT(CPB),
    .CNT_W       (5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rxd  (rxd),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         n_ferr = 0;
  int         n_ovr  = 0;
  int         n_rise = 0;
  bit         busy_seen = 1'b0;
  logic       prev_valid = 1'b0;
  time        t_rise_first = 0;
  time        t_f1;
  time        t_dummy;

  always @(negedge clk) begin
    if (bus.rx_valid && !prev_valid) begin
      if (n_rise == 0) t_rise_first = $time;
      n_rise++;
    end
    prev_valid = bus.rx_valid;
    if (bus.rx_valid && bus.rx_ready) got_q.push_back(bus.rx_data);
    if (bus.frame_err) n_ferr++;
    if (bus.overrun) n_ovr++;
    if (bus.busy) busy_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk);
    got_q.delete();
    exp_q.delete();
    n_ferr    = 0;
    n_ovr     = 0;
    n_rise    = 0;
    busy_seen = 1'b0;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 bus.rx_ready = v;
  endtask

  // One 8N1 frame, LSB first, each bit lasting per time units
  task automatic send(input logic [7:0] b, input logic stop, input int per, output time t_f);
    @(negedge clk);
    t_f = $time;
    rxd = 1'b0;
    #per;
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #per;
    end
    rxd = stop;
    #per;
  endtask

  task automatic check_q(input string tag);
    int n;
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_data"},  32'(bus.rx_data),   32'h00);
    chk({tag, "_valid"}, 32'(bus.rx_valid),  32'h0);
    chk({tag, "_busy"},  32'(bus.busy),      32'h0);
    chk({tag, "_ferr"},  32'(bus.frame_err), 32'h0);
    chk({tag, "_ovr"},   32'(bus.overrun),   32'h0);
  endtask

  initial begin
    logic [7:0] b;
    int         per;
    int         pend;
    int         exp_ovr;

    bus.rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Back-to-back frames with a ready consumer, plus first-byte latency
    clear_mon();
    send(8'h55, 1'b1, BIT, t_f1);
    exp_q.push_back(8'h55);
    send(8'hA3, 1'b1, BIT, t_dummy);
    exp_q.push_back(8'hA3);
    repeat (4) @(negedge clk);
    check_q("b2b");
    chk("b2b_ferr", 32'(n_ferr), 0);
    chk("b2b_ovr", 32'(n_ovr), 0);
    // fall->edge-visible is 2 clocks, then stop sample at +CPB/2+9*CPB, visible one later
    chk("latency", 32'((t_rise_first - t_f1) / T), 32'(2 + CPB / 2 + 9 * CPB + 1));

    // Five-clock glitch: start check finds the line high again
    clear_mon();
    @(negedge clk);
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    rxd = 1'b1;
    repeat (6) @(negedge clk);
    chk("glitch_busy_end", 32'(bus.busy), 0);
    chk("glitch_busy_seen", 32'(busy_seen), 1);
    repeat (30) @(negedge clk);
    chk("glitch_valid", 32'(n_rise), 0);
    chk("glitch_ferr", 32'(n_ferr), 0);

    // Bad stop bit followed by a held-low line
    clear_mon();
    send(8'h0F, 1'b0, BIT, t_dummy);
    repeat (40) @(negedge clk);
    chk("brk_ferr", 32'(n_ferr), 1);
    chk("brk_valid", 32'(n_rise), 0);
    chk("brk_busy_hold", 32'(bus.busy), 1);
    rxd = 1'b1;
    repeat (6) @(negedge clk);
    chk("brk_busy_end", 32'(bus.busy), 0);
    chk("brk_ferr_once", 32'(n_ferr), 1);

    // Stalled consumer: every commit over a pending byte is an overrun
    set_ready(1'b0);
    clear_mon();
    pend    = 0;
    exp_ovr = 0;
    send(8'h11, 1'b1, BIT, t_dummy);
    if (pend != 0) exp_ovr++;
    pend = 1;
    send(8'h22, 1'b1, BIT, t_dummy);
    if (pend != 0) exp_ovr++;
    pend = 1;
    repeat (4) @(negedge clk);
    chk("ovr_count", 32'(n_ovr), 32'(exp_ovr));
    chk("ovr_valid", 32'(bus.rx_valid), 32'(pend));
    chk("ovr_data", 32'(bus.rx_data), 32'h22);
    set_ready(1'b1);
    @(posedge clk);
    #1 chk("ovr_accept", 32'(bus.rx_valid), 0);
    exp_q.push_back(8'h22);
    check_q("ovr_q");

    // Reset in the middle of bit 4, then a clean frame
    clear_mon();
    b = 8'hC6;
    @(negedge clk);
    rxd = 1'b0;
    #BIT;
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      #BIT;
    end
    rxd = b[4];
    #(BIT / 2);
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    clear_mon();
    send(8'h3C, 1'b1, BIT, t_dummy);
    exp_q.push_back(8'h3C);
    repeat (4) @(negedge clk);
    check_q("midrst_q");
    chk("midrst_data", 32'(bus.rx_data), 32'h3C);

    // Line already low when reset releases must not open a frame
    @(posedge clk);
    #1 rst_n = 1'b0;
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    clear_mon();
    #1 rst_n = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("lowrel_busy", 32'(busy_seen), 0);
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    chk("lowrel_ferr", 32'(n_ferr), 0);

    // Transmitter about 2% fast and 2% slow
    clear_mon();
    send(8'h96, 1'b1, BIT - 3, t_dummy);
    exp_q.push_back(8'h96);
    send(8'h96, 1'b1, BIT + 3, t_dummy);
    exp_q.push_back(8'h96);
    repeat (4) @(negedge clk);
    check_q("rate");
    chk("rate_ferr", 32'(n_ferr), 0);

    // Random bytes, random rate within tolerance, random idle gaps
    clear_mon();
    for (int k = 0; k < 10; k++) begin
      b   = 8'($urandom);
      per = BIT - 3 + int'($urandom_range(0, 6));
      repeat ($urandom_range(0, 20)) @(negedge clk);
      send(b, 1'b1, per, t_dummy);
      exp_q.push_back(b);
    end
    repeat (4) @(negedge clk);
    check_q("rand");
    chk("rand_ferr", 32'(n_ferr), 0);
    chk("rand_ovr", 32'(n_ovr), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_1200.md
# uart_rx_1200

Serial receiver for the 1200-baud 8N1 link, the receiving end of the baud-clocked transmit path. It runs directly on the 12 MHz system clock and times bits with its own counter, so it needs no separate baud clock. The block synchronises the asynchronous line, detects and qualifies the start bit, and samples each bit at mid-bit. It delivers each byte through a valid/ready holding register and flags framing and overrun errors.

## Interface
- CLKS_PER_BIT, default 10000: system clocks per bit (12 MHz / 1200); must be ≥ 4
- CNT_W, default 14: bit-timer width; 2^CNT_W > CLKS_PER_BIT
- clk  input  1  system clock, 12 MHz, rising edge
- rst_n  input  1  reset, asynchronous assert, active-low; all flops clear immediately
- rxd  input  1  serial line, asynchronous, idle high
- rx_data  output  8  last received byte, LSB = first data bit
- rx_valid  output  1  byte available; held until accepted
- rx_ready  input  1  consumer accepts byte when rx_valid & rx_ready at a clk edge
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: new byte completed while rx_valid still high
- busy  output  1  high in every state except IDLE

## Operation
- rxd passes through a 2-flop synchroniser; its reset value is 1. All logic uses the synchronised value rxs and its previous value rxs_d.
- Start edge: rxs_d=1 & rxs=0 while in IDLE.
- States:
  - IDLE: on start edge, load timer=0 and go to START.
  - START: when timer = CLKS_PER_BIT/2 − 1 (integer division), sample rxs.
    - If rxs=0: go to DATA with bit index 0 and timer cleared.
    - If rxs=1: treat as a glitch and return to IDLE with no outputs.
  - DATA: when timer = CLKS_PER_BIT − 1, shift rxs into bit[index], clear timer and increment index. After index 7 is sampled, go to STOP.
  - STOP: when timer = CLKS_PER_BIT − 1, sample rxs.
    - If rxs=1: commit the byte and go to IDLE.
    - If rxs=0: pulse frame_err, do not commit, and go to BREAK.
  - BREAK: wait for rxs=1, then go to IDLE. A held-low line (break) produces exactly one frame_err.
- Commit:
  - rx_data is loaded and rx_valid is set.
  - If rx_valid was already 1 and not being accepted in the same cycle, overrun pulses and rx_data is overwritten with the new byte.
- Accept: rx_valid & rx_ready clears rx_valid next cycle. Commit and accept in the same cycle leave rx_valid=1 with the new byte and no overrun.
- Timer increments every clk in START/DATA/STOP and is held at 0 in IDLE/BREAK. It never wraps.
- Reset values: rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0, state IDLE, synchroniser=1.
- Reset mid-frame discards the partial byte. After release, the block waits for a fresh 1→0 edge, so a line already low does not start a frame.

## Timing
- Let t0 be the cycle where the start edge is detected; rxd falls 2–3 clocks earlier because of the synchroniser.
- Start check: t0 + CLKS_PER_BIT/2.
- Data bit i (i = 0..7) sampled at t0 + CLKS_PER_BIT/2 + (i+1)·CLKS_PER_BIT.
- Stop sampled at t0 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
- rx_valid, frame_err and overrun are registered and visible the cycle after the stop sample.
- busy rises the cycle after t0 and falls the cycle after the stop sample, or after BREAK exits.
- Back-to-back frames: a new start edge is accepted in the first IDLE cycle. Transmitter rate error of ±2% is tolerated.
- rx_ready has no combinational path to any output.

## Test plan
- CLKS_PER_BIT=16. Send 0x55 then 0xA3 back-to-back with rx_ready=1 → rx_valid pulses twice with rx_data 0x55, 0xA3; no frame_err or overrun; first rx_valid at t0+153.
- Drive a 5-clock low glitch on idle rxd → no busy after START abort, no rx_valid, state back in IDLE by t0+9.
- Send 0x0F with stop bit driven 0, then hold rxd low 40 clocks → exactly one frame_err pulse, rx_valid stays 0, busy stays high until rxd returns high.
- rx_ready=0; send 0x11 then 0x22 → first commit sets rx_valid; second pulses overrun once; rx_data=0x22; raising rx_ready clears rx_valid next cycle.
- Assert rst_n=0 during bit 4 of 0xC6, release with rxd high, then send 0x3C → no byte from the aborted frame; rx_data=0x3C; outputs are at reset values during reset.
- Transmit 0x96 at bit period 16±0.3 clocks (≈2% fast and slow) → rx_data=0x96 in both cases, no frame_err.
